// File: rtl/ram_latency_responder_if.sv
// Request/response bundle between a requester (CPU or testbench mux) and the
// fixed-latency RAM responder.
interface ram_latency_responder_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_latency_responder.sv
// Word RAM that answers cpu_ram_if requests after a fixed LAT-cycle latency.
// Optional RAM_ALIGN_CHECK_EN: misaligned requests are reported as ERROR.
module ram_latency_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input logic                     CLK,
  input logic                     nRST,
  ram_latency_responder_if.slave  ram
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   lat_idx;
  logic            lat_wr;
  logic [31:0]     ramload_r;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            oob;
  logic            misalign;
  logic            bad;
  logic            changed;
  logic [AW-1:0]   idx;

  assign req = ram.ramREN | ram.ramWEN;
  assign oob = ram.ramaddr[31:2] >= 30'(DEPTH);
  assign idx = ram.ramaddr[AW+1:2];

`ifdef RAM_ALIGN_CHECK_EN
  assign misalign = req & (ram.ramaddr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ram.ramaddr[1:0];
  assign misalign        = 1'b0;
`endif

  assign bad     = (ram.ramREN & ram.ramWEN) | oob | misalign;
  // Requester must hold the same word and op for the whole wait.
  assign changed = !req || bad || (idx != lat_idx) || (ram.ramWEN != lat_wr);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_idx   <= '0;
      lat_wr    <= 1'b0;
      ramload_r <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && !bad) begin
            lat_idx <= idx;
            lat_wr  <= ram.ramWEN;
            if (LAT == 1) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (changed) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'(LAT - 1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          // Always return to IDLE so a held request pays full latency again.
          state <= IDLE;
          cnt   <= 4'd0;
          if (!lat_wr && !bad) begin
            ramload_r <= mem[lat_idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // State is forced to IDLE by reset, so no write can fire while nRST is low.
  always_ff @(posedge CLK) begin
    if (state == DONE && lat_wr && !bad) begin
      mem[lat_idx] <= ram.ramstore;
    end
  end

  assign ram.ramload = (state == DONE && !lat_wr) ? mem[lat_idx] : ramload_r;

  always_comb begin
    ram.ramstate = FREE;
    if (!nRST) begin
      ram.ramstate = FREE;
    end else if (bad) begin
      ram.ramstate = ERROR;
    end else begin
      unique case (state)
        IDLE:    ram.ramstate = req ? BUSY : FREE;
        WAIT:    ram.ramstate = BUSY;
        DONE:    ram.ramstate = ACCESS;
        default: ram.ramstate = FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_latency_responder.sv
// Randomized bench for ram_latency_responder: two instances (LAT=4, LAT=1) share
// one stimulus stream and are compared every cycle against a request-age model.
module tb_ram_latency_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT_A = 4;
  localparam int unsigned LAT_B = 1;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  ram_latency_responder_if bus_a ();
  ram_latency_responder_if bus_b ();

  assign bus_b.ramREN   = bus_a.ramREN;
  assign bus_b.ramWEN   = bus_a.ramWEN;
  assign bus_b.ramaddr  = bus_a.ramaddr;
  assign bus_b.ramstore = bus_a.ramstore;

  ram_latency_responder #(.LAT(LAT_A), .DEPTH(DEPTH)) dut_a (
    .CLK  (CLK),
    .nRST (nRST),
    .ram  (bus_a.slave)
  );

  ram_latency_responder #(.LAT(LAT_B), .DEPTH(DEPTH)) dut_b (
    .CLK  (CLK),
    .nRST (nRST),
    .ram  (bus_b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: an accepted request ages by one per cycle and shows ACCESS at age LAT.
  int          lat_m  [2];
  bit          busy_m [2];
  int          age_m  [2];
  int          idx_m  [2];
  bit          wr_m   [2];
  logic [31:0] load_m [2];
  logic [31:0] mem_m  [2][DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pf(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic m_req();
    return bus_a.ramREN | bus_a.ramWEN;
  endfunction

  function automatic logic m_bad();
    logic b;
    b = (bus_a.ramREN & bus_a.ramWEN) | ((bus_a.ramaddr >> 2) >= 32'(DEPTH));
`ifdef RAM_ALIGN_CHECK_EN
    if (m_req() && bus_a.ramaddr[1:0] != 2'b00) b = 1'b1;
`endif
    return b;
  endfunction

  function automatic logic [1:0] exp_state(input int k);
    if (!nRST) return FREE;
    if (m_bad()) return ERROR;
    if (busy_m[k] && age_m[k] == lat_m[k]) return ACCESS;
    if (busy_m[k]) return BUSY;
    return m_req() ? BUSY : FREE;
  endfunction

  function automatic logic [31:0] exp_load(input int k);
    if (nRST && busy_m[k] && age_m[k] == lat_m[k] && !wr_m[k]) return mem_m[k][idx_m[k]];
    return load_m[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      busy_m[k] = 1'b0;
      age_m[k]  = 0;
      load_m[k] = 32'd0;
    end
  endtask

  task automatic model_edge();
    logic bad;
    int   cur;
    bad = m_bad();
    cur = int'(bus_a.ramaddr >> 2);
    for (int k = 0; k < 2; k++) begin
      if (busy_m[k]) begin
        if (age_m[k] == lat_m[k]) begin
          if (!bad) begin
            if (wr_m[k]) mem_m[k][idx_m[k]] = bus_a.ramstore;
            else         load_m[k] = mem_m[k][idx_m[k]];
          end
          busy_m[k] = 1'b0;
        end else if (!m_req() || bad || cur != idx_m[k] || bus_a.ramWEN != wr_m[k]) begin
          busy_m[k] = 1'b0;
        end else begin
          age_m[k]++;
        end
      end else if (m_req() && !bad) begin
        busy_m[k] = 1'b1;
        age_m[k]  = 1;
        idx_m[k]  = cur;
        wr_m[k]   = bus_a.ramWEN;
      end
    end
  endtask

  task automatic check_outputs();
    check("state_a", 32'(bus_a.ramstate), 32'(exp_state(0)));
    check("load_a",  bus_a.ramload,       exp_load(0));
    check("state_b", 32'(bus_b.ramstate), 32'(exp_state(1)));
    check("load_b",  bus_b.ramload,       exp_load(1));
  endtask

  // Called at posedge+1: drive, sample at the falling edge, then advance the model.
  task automatic cycle(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] store);
    bus_a.ramREN   = ren;
    bus_a.ramWEN   = wen;
    bus_a.ramaddr  = addr;
    bus_a.ramstore = store;
    #4;
    check_outputs();
    @(posedge CLK);
    if (nRST) model_edge();
    #1;
  endtask

  task automatic hold(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] store, input int n);
    for (int i = 0; i < n; i++) cycle(ren, wen, addr, store);
  endtask

  task automatic idle(input int n);
    hold(1'b0, 1'b0, 32'd0, 32'd0, n);
  endtask

  initial begin
    lat_m[0] = LAT_A;
    lat_m[1] = LAT_B;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = 'x;

    nRST = 1'b0;
    bus_a.ramREN   = 1'b0;
    bus_a.ramWEN   = 1'b0;
    bus_a.ramaddr  = 32'd0;
    bus_a.ramstore = 32'd0;
    model_reset();
    #2;
    check_outputs();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle(2);

    for (int i = 0; i < DEPTH; i++) hold(1'b0, 1'b1, 32'(4 * i), pf(i), LAT_A + 1);
    idle(1);

    // Basic write then read of 0x40
    hold(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, LAT_A + 1);
    idle(1);
    hold(1'b1, 1'b0, 32'h40, 32'd0, LAT_A + 1);
    idle(2);
    check("read_0x40", bus_a.ramload, 32'hDEAD_BEEF);

    // Abort: address moves from 0x80 to 0x84 mid-wait
    hold(1'b0, 1'b1, 32'h80, 32'h1111_1111, 2);
    hold(1'b0, 1'b1, 32'h84, 32'h2222_2222, 6);
    idle(1);
    hold(1'b1, 1'b0, 32'h80, 32'd0, LAT_A + 1);
    idle(1);
    check("abort_0x80", bus_a.ramload, pf(32));
    hold(1'b1, 1'b0, 32'h84, 32'd0, LAT_A + 1);
    idle(1);
    check("read_0x84", bus_a.ramload, 32'h2222_2222);

    // Misaligned read of 0x42
    hold(1'b1, 1'b0, 32'h42, 32'd0, LAT_A + 1);
    idle(1);
`ifdef RAM_ALIGN_CHECK_EN
    check("misalign", bus_a.ramload, 32'h2222_2222);
`else
    check("misalign", bus_a.ramload, 32'hDEAD_BEEF);
`endif

    // Errors: both enables, then out of range, then legal again
    hold(1'b1, 1'b1, 32'h40, 32'h0BAD_0BAD, LAT_A + 1);
    hold(1'b0, 1'b1, 32'(4 * DEPTH), 32'h0BAD_0BAD, LAT_A + 1);
    hold(1'b1, 1'b0, 32'h40, 32'd0, LAT_A + 1);
    idle(1);
    check("err_nowrite", bus_a.ramload, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a write to 0x10
    hold(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 2);
    #1;
    nRST = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle(1);
    hold(1'b1, 1'b0, 32'h10, 32'd0, LAT_A + 1);
    idle(1);
    check("reset_drop", bus_a.ramload, pf(4));

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      int          op;
      int          sel;
      int          n;
      logic [31:0] addr;
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 9);
      n   = $urandom_range(1, 8);
      if (sel == 0)      addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      else if (sel == 1) addr = 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
      else               addr = 32'(4 * $urandom_range(0, 7));
      for (int i = 0; i < n; i++) begin
        logic [31:0] st;
        st = $urandom;
        if (op < 2)       cycle(1'b0, 1'b0, addr, st);
        else if (op < 6)  cycle(1'b1, 1'b0, addr, st);
        else if (op < 9)  cycle(1'b0, 1'b1, addr, st);
        else              cycle(1'b1, 1'b1, addr, st);
      end
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_latency_responder.md
Name: ram_latency_responder

Overview:
- Memory-side responder for the cpu_ram_if request/response protocol.
- Accepts word read/write requests on the ram* signals, models a fixed access latency with a state machine and counter, and returns ramstate and ramload.
- Sits where the behavioural RAM sits under the system top: the driven ramREN/ramWEN/ramaddr/ramstore come from the CPU or testbench mux.
- Provides a deterministic, parameterisable-latency memory for pipeline and cache bring-up.

Parameters:
- LAT, 2, cycles from first request cycle to ACCESS cycle; legal range 1..15.
- DEPTH, 256, number of 32-bit words stored; power of two, 2..4096.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- ramREN  input  1  read request; held by the requester until it sees ACCESS.
- ramWEN  input  1  write request; held by the requester until it sees ACCESS.
- ramaddr  input  32  byte address; word index = ramaddr[31:2].
- ramstore  input  32  write data; sampled on the edge that ends the ACCESS cycle.
- ramload  output  32  read data; valid during the ACCESS cycle of a read.
- ramstate  output  2  response status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Interface: one clock (CLK); reset nRST is asynchronous, active-low.
- Reset values:
  - state IDLE, counter 0, latched address 0, latched op 0, ramload 0.
  - ramstate is FREE while nRST is low.
  - Memory array is not cleared by reset; contents are X until written.
- States: IDLE, WAIT, DONE.
- "req" = ramREN | ramWEN.
- "bad":
  - ramREN & ramWEN, or
  - ramaddr[31:2] >= DEPTH.
- ramstate is combinational from state and inputs:
  - bad in any state -> ERROR (overrides everything).
  - IDLE: FREE if !req, BUSY if req.
  - WAIT -> BUSY.
  - DONE -> ACCESS.
- IDLE transitions:
  - req & !bad: latch ramaddr and op (read/write).
  - If LAT==1, go to DONE; else go to WAIT with counter=1.
  - !req or bad: stay in IDLE.
- WAIT transitions:
  - Abort to IDLE if req drops, bad, ramaddr != latched address, or op differs from latched op. No write occurs on abort.
  - Otherwise increment the counter; go to DONE when counter == LAT-1.
- Timing guarantee: a request first asserted in cycle 0 and held unchanged sees ACCESS in cycle LAT.
- DONE (exactly one cycle):
  - Read: ramload = mem[latched word index] combinationally during ACCESS; the value is registered so ramload holds it after ACCESS.
  - Write: mem[latched index] <= ramstore on the edge ending ACCESS.
  - Next state is always IDLE, even if the request is still held. A still-held request starts a fresh access with full latency (ramstate shows BUSY in the next cycle).
- Abort and new-request re-evaluation: in the same edge that aborts WAIT, a new valid request is not accepted. The FSM enters IDLE, then accepts the request on the following edge, so BUSY is shown continuously.
- ramload outside ACCESS: holds the last read value; writes do not change it.
- Back-to-back accesses: minimum spacing is LAT+1 cycles per access. There is no pipelining.
- ramaddr[1:0] is ignored unless the optional feature is enabled.
- Reset mid-operation: an in-flight write that has not yet passed its ACCESS edge is dropped. Memory words already written keep their values.

Optional Feature:
- Macro RAM_ALIGN_CHECK_EN.
- Defined: ramaddr[1:0] != 0 with req counts as bad, giving ERROR with no state progression and no write.
- Undefined: low two address bits are ignored; a misaligned access behaves as the aligned word access.

Test Plan:
- Basic latency: LAT=2. Write 0xDEADBEEF to 0x40 (ramWEN held) -> ramstate BUSY in cycles 0-1 and ACCESS in cycle 2. Then read 0x40 -> ACCESS in cycle 2 with ramload=0xDEADBEEF; ramload holds after ACCESS.
- LAT=1 and LAT=15: a read held from cycle 0 -> ACCESS exactly in cycle 1 or cycle 15, a single ACCESS cycle, then BUSY again while held.
- Abort: LAT=4, write 0x11111111 to 0x80, change ramaddr to 0x84 in cycle 2 -> no ACCESS for 0x80. The access at 0x84 completes with ACCESS in cycle 7. A later read of 0x80 returns the prior contents.
- Errors:
  - ramREN=ramWEN=1 -> ERROR the same cycle, no write.
  - ramaddr=4*DEPTH -> ERROR.
  - Dropping back to a legal request -> FREE/BUSY resumes with full latency.
- Reset mid-op: assert nRST low during WAIT of a write to 0x10 -> ramstate FREE immediately, ramload=0, mem[0x10] unchanged. Async: reset asserted between clock edges takes effect before the next edge.
- Alignment (RAM_ALIGN_CHECK_EN defined vs not): read 0x42 -> ERROR with the macro. Without it, read 0x42 returns the 0x40 word after LAT cycles.
